// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between requester A (CPU)
// and requester B (DMA/debug loader). One access per cycle, round-robin on
// ties, bounded locked bursts, and read data returned registered one cycle
// after the grant.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    localparam logic [1:0] OWN_FREE   = 2'd0;
    localparam logic [1:0] OWN_LOCK_A = 2'd1;
    localparam logic [1:0] OWN_LOCK_B = 2'd2;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    logic [1:0]        owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              grant_a, grant_b;

    // Pick the winner: a live lock wins outright, otherwise round-robin on ties;
    // nothing is granted while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end else if (owner_q == OWN_LOCK_A && a_req) begin
            grant_a = 1'b1;
        end else if (owner_q == OWN_LOCK_B && b_req) begin
            grant_b = 1'b1;
        end else if (a_req && b_req) begin
            grant_a = (last_gnt_q == LAST_B);
            grant_b = (last_gnt_q == LAST_A);
        end else begin
            grant_a = a_req;
            grant_b = b_req;
        end
    end

    // Steer the granted requester onto the memory port; idle port drives zeros.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_a) begin
            mem_read  = ~a_we;
            mem_write = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (grant_b) begin
            mem_read  = ~b_we;
            mem_write = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // Next ownership: extend a lock only while the burst is under its limit.
    always_comb begin
        owner_d     = OWN_FREE;
        burst_cnt_d = '0;
        last_gnt_d  = last_gnt_q;
        if (grant_a) begin
            last_gnt_d = LAST_A;
            if (a_lock && burst_cnt_q < CNT_LAST) begin
                owner_d     = OWN_LOCK_A;
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end else if (grant_b) begin
            last_gnt_d = LAST_B;
            if (b_lock && burst_cnt_q < CNT_LAST) begin
                owner_d     = OWN_LOCK_B;
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end
    end

    // Capture read data for the port whose read was granted; others hold.
    always_comb begin
        a_rvalid_d = grant_a & ~a_we;
        b_rvalid_d = grant_b & ~b_we;
        a_rdata_d  = a_rvalid_d ? mem_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_rdata : b_rdata_q;
    end

    // State registers; reset frees the lock and gives A the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_FREE;
            last_gnt_q  <= LAST_B;
            burst_cnt_q <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign a_gnt    = grant_a;
    assign b_gnt    = grant_b;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter, checked every cycle
// against a behavioural model of the arbitration rules, plus hand-computed
// literal expectations at key points.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the arbiter: word i starts as i+4, combinational read.
    logic [31:0] dmem [0:63];
    logic        mem_ready = 1'b0;
    assign mem_rdata = dmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'(i + 4);
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            dmem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // Model state: who holds a lock (-1 nobody, 0 A, 1 B), who won last,
    // beats granted so far in the current lock, and expected read returns.
    int          m_locked_to = -1;
    int          m_last      = 1;
    int          m_beats     = 0;
    logic        m_rvalid [2] = '{1'b0, 1'b0};
    logic [31:0] m_rdata  [2] = '{32'h0, 32'h0};
    logic [31:0] ref_mem  [0:63];
    logic        ref_ready = 1'b0;

    // Winner this cycle according to the arbitration rules.
    function automatic int winner();
        if (rst) return -1;
        if (m_locked_to == 0 && a_req) return 0;
        if (m_locked_to == 1 && b_req) return 1;
        if (a_req && b_req) return (m_last == 0) ? 1 : 0;
        if (a_req) return 0;
        if (b_req) return 1;
        return -1;
    endfunction

    int          u_w;
    logic        u_we, u_lock;
    logic [31:0] u_addr, u_wdata;

    // Advance the model at each edge the DUT would act on.
    always @(posedge clk or posedge rst) begin
        if (!ref_ready) begin
            for (int i = 0; i < 64; i++) ref_mem[i] <= 32'(i + 4);
            ref_ready <= 1'b1;
        end
        if (rst) begin
            m_locked_to <= -1;
            m_last      <= 1;
            m_beats     <= 0;
            m_rvalid[0] <= 1'b0;
            m_rvalid[1] <= 1'b0;
            m_rdata[0]  <= 32'h0;
            m_rdata[1]  <= 32'h0;
        end else begin
            u_w = winner();
            m_rvalid[0] <= 1'b0;
            m_rvalid[1] <= 1'b0;
            if (u_w < 0) begin
                m_locked_to <= -1;
                m_beats     <= 0;
            end else begin
                u_we    = (u_w == 0) ? a_we    : b_we;
                u_lock  = (u_w == 0) ? a_lock  : b_lock;
                u_addr  = (u_w == 0) ? a_addr  : b_addr;
                u_wdata = (u_w == 0) ? a_wdata : b_wdata;
                m_last <= u_w;
                if (u_we) begin
                    ref_mem[u_addr[7:2]] <= u_wdata;
                end else begin
                    m_rvalid[u_w] <= 1'b1;
                    m_rdata[u_w]  <= ref_mem[u_addr[7:2]];
                end
                if (u_lock && m_beats + 1 < MAX_BURST) begin
                    m_locked_to <= u_w;
                    m_beats     <= m_beats + 1;
                end else begin
                    m_locked_to <= -1;
                    m_beats     <= 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    int          c_w;
    logic [31:0] c_addr, c_wdata;
    logic        c_we;

    // Compare every DUT output against the model, away from the rising edge.
    always @(negedge clk) begin
        c_w     = winner();
        c_we    = (c_w == 0) ? a_we    : (c_w == 1) ? b_we    : 1'b0;
        c_addr  = (c_w == 0) ? a_addr  : (c_w == 1) ? b_addr  : 32'h0;
        c_wdata = (c_w == 0) ? a_wdata : (c_w == 1) ? b_wdata : 32'h0;
        checkOutput("a_gnt", a_gnt, c_w == 0);
        checkOutput("b_gnt", b_gnt, c_w == 1);
        checkOutput("gnt_exclusive", a_gnt & b_gnt, 0);
        checkOutput("mem_read", mem_read, (c_w >= 0) && !c_we);
        checkOutput("mem_write", mem_write, (c_w >= 0) && c_we);
        checkOutput("mem_addr", mem_addr, c_addr);
        checkOutput("mem_wdata", mem_wdata, c_wdata);
        checkOutput("a_rvalid", a_rvalid, m_rvalid[0]);
        checkOutput("a_rdata", a_rdata, m_rdata[0]);
        checkOutput("b_rvalid", b_rvalid, m_rvalid[1]);
        checkOutput("b_rdata", b_rdata, m_rdata[1]);
    end

    task automatic driveInputs(input logic ar, input logic aw, input logic al,
                               input logic [31:0] aa, input logic [31:0] ad,
                               input logic br, input logic bw, input logic bl,
                               input logic [31:0] ba, input logic [31:0] bd);
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    endtask

    // Drive one cycle's inputs just after the edge and return at mid-cycle.
    task automatic applyStimulus(input logic ar, input logic aw, input logic al,
                                 input logic [31:0] aa, input logic [31:0] ad,
                                 input logic br, input logic bw, input logic bl,
                                 input logic [31:0] ba, input logic [31:0] bd);
        @(posedge clk);
        #1;
        driveInputs(ar, aw, al, aa, ad, br, bw, bl, ba, bd);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        driveInputs(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("lit_reset_gnt", {a_gnt, b_gnt}, 2'b00);
        checkOutput("lit_reset_rvalid", {a_rvalid, b_rvalid}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single A read of word 16.
        applyStimulus(1, 0, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("lit_a_gnt_same_cycle", {a_gnt, mem_read, mem_write}, 3'b110);
        checkOutput("lit_mem_addr_40", mem_addr, 32'h40);
        idleCycle();
        checkOutput("lit_a_rvalid_next", a_rvalid, 1'b1);
        checkOutput("lit_a_rdata_14", a_rdata, 32'h14);
        idleCycle();
        checkOutput("lit_a_rvalid_pulse", a_rvalid, 1'b0);

        // B goes once so the tie sequence starts with A.
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h48, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 32'h50, 32'h0, 1, 0, 0, 32'h4C, 32'h0);
            checkOutput($sformatf("lit_rr_%0d", i), {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // B writes, A reads the same word back.
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h44, 32'hDEADBEEF);
        checkOutput("lit_b_write", {b_gnt, mem_write}, 2'b11);
        applyStimulus(1, 0, 0, 32'h44, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        idleCycle();
        checkOutput("lit_a_rdata_beef", a_rdata, 32'hDEADBEEF);
        checkOutput("lit_b_rdata_kept", b_rdata, 32'h17);

        // Locked burst from A against a continuous B.
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h48, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, 32'h60, 32'h0, 1, 0, 0, 32'h64, 32'h0);
            checkOutput($sformatf("lit_burst_%0d", i), {a_gnt, b_gnt}, (i == 4) ? 2'b01 : 2'b10);
        end

        // Second locked beat, then A drops its request: B gets in.
        applyStimulus(1, 0, 1, 32'h60, 32'h0, 1, 0, 0, 32'h64, 32'h0);
        checkOutput("lit_lock_beat2", a_gnt, 1'b1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h64, 32'h0);
        checkOutput("lit_lock_void", {a_gnt, b_gnt}, 2'b01);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 1, 32'h60, 32'h0, 1, 0, 0, 32'h64, 32'h0);
            checkOutput($sformatf("lit_fresh_burst_%0d", i), {a_gnt, b_gnt}, (i == 4) ? 2'b01 : 2'b10);
        end

        // Reset with a read just returned and B holding a lock.
        applyStimulus(1, 0, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h48, 32'h0);
        checkOutput("lit_pre_reset_rvalid", a_rvalid, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        driveInputs(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h48, 32'h12345678);
        @(negedge clk);
        checkOutput("lit_rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
        checkOutput("lit_rst_rdata", {a_rdata, b_rdata}, 64'h0);
        checkOutput("lit_rst_no_write", {b_gnt, mem_write}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        driveInputs(1, 0, 0, 32'h40, 32'h0, 1, 0, 1, 32'h48, 32'h0);
        @(negedge clk);
        checkOutput("lit_post_reset_tie", {a_gnt, b_gnt}, 2'b10);
        idleCycle();
        checkOutput("lit_post_reset_read", a_rdata, 32'h14);
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory between requester A (CPU load/store stage) and requester B (DMA/debug loader).
- Accepts at most one access per cycle, with round-robin fairness.
- Supports bounded locked bursts.
- Drives the memory's combinational-read / synchronous-write port and returns read data registered, one cycle after grant.

Parameters:
ADDR_W, 32, address width passed through to memory
DATA_W, 32, data width
MAX_BURST, 4, max consecutive locked grants to one requester (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
a_req  input  1  A requests an access this cycle
a_we  input  1  A access is write (1) / read (0)
a_lock  input  1  A requests to keep grant for next beat
a_addr  input  ADDR_W  A byte address
a_wdata  input  DATA_W  A write data
a_gnt  output  1  A access accepted this cycle (combinational)
a_rvalid  output  1  A read data valid (1-cycle pulse)
a_rdata  output  DATA_W  A read data (registered)
b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for B
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory combinational read data

Behaviour:
- State registers:
  - owner ∈ {FREE, LOCK_A, LOCK_B}
  - last_gnt (0=A, 1=B)
  - burst_cnt (clog2(MAX_BURST) bits)
  - rdata/rvalid registers per port
- Reset values (async):
  - owner=FREE, last_gnt=B (A wins first tie), burst_cnt=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - While rst is high: a_gnt=b_gnt=0, mem_read=mem_write=0, mem_addr=mem_wdata=0.
- Grant selection (combinational, same cycle as req):
  - owner=LOCK_X and x_req=1 -> grant X, regardless of the other request.
  - owner=LOCK_X and x_req=0 -> lock void; arbitrate as FREE in the same cycle.
  - FREE with both req -> grant the requester != last_gnt.
  - FREE with one req -> grant it. No req -> no grant.
  - At most one of a_gnt/b_gnt is high.
- Memory drive:
  - When X is granted: mem_addr=x_addr, mem_wdata=x_wdata, mem_write=x_we, mem_read=~x_we.
  - When no grant: mem_read=mem_write=0, mem_addr/mem_wdata=0.
- Write commits at the rising edge ending the grant cycle.
- Read latency 1:
  - On the edge ending a read grant to X, x_rdata<=mem_rdata and x_rvalid<=1.
  - x_rvalid is 0 on every other cycle.
  - x_rdata holds its value until X's next read completes.
  - A write grant does not change x_rdata.
- State update on each edge with a grant to X:
  - last_gnt<=X.
  - If x_lock=1 and burst_cnt<MAX_BURST-1: owner<=LOCK_X, burst_cnt<=burst_cnt+1.
  - Else: owner<=FREE, burst_cnt<=0. Reaching the limit forces release, so the other requester wins the next tie.
- No grant: owner<=FREE, burst_cnt<=0.
- MAX_BURST=1: locking is disabled, pure round-robin.
- Requesters hold req/we/addr/wdata stable until they see gnt.
- A requester may deassert req without a grant (no commitment).
- Reset mid-burst or mid-read: the lock is cleared, a pending rvalid is suppressed (it reads 0 after reset), and no memory write occurs while rst is high.
- Back-to-back grants to the same port:
  - Allowed every cycle; rvalid stays high on consecutive read beats.
  - rdata updates each cycle.

Test Plan:
- Reset then single A read addr 0x40 (memory word 16 = 0x14) -> a_gnt=1 same cycle, mem_read=1 mem_addr=0x40; next cycle a_rvalid=1, a_rdata=0x00000014, then a_rvalid=0.
- A and B both request every cycle, no lock, for 6 cycles -> grants alternate A,B,A,B,A,B; no cycle has both gnt high.
- B write 0xDEADBEEF to 0x44, then A read 0x44 in the following cycle -> a_rdata=0xDEADBEEF; b_rdata unchanged.
- A lock=1 and continuous req, B req continuous, MAX_BURST=4 -> A granted 4 consecutive cycles, B granted 5th cycle, A granted 6th.
- A locked after 2 beats drops req for one cycle while B requests -> B granted that cycle, owner returns to FREE, burst_cnt=0.
- Assert rst in the cycle after an A read grant and during an active B lock -> a_rvalid=0, a_rdata=0, owner FREE; after release, a tie grants A first.
